// File: rtl/ad_capture_ctrl.sv
// ad_capture_ctrl
//   Capture sequencer for the paired current/voltage ADC sample stream.
//   After an arm pulse it fills a circular sample RAM with pre-trigger
//   history, waits for a rising-edge current-level trigger (or a software
//   force), writes the post-trigger samples and parks in DONE. Host logic
//   then reads the RAM starting at rec_start.
//
// Ports
//   sys_clk, rst_n            clock, asynchronous active-low reset
//   smp_valid                 sample pair present this cycle
//   smp_current, smp_voltage  signed sample channels
//   arm, abort                single-cycle control pulses
//   trig_force                software force-trigger request
//   decim                     keep 1 of every decim+1 valid samples
//   pre_len, post_len         pre/post trigger sample counts (post includes trigger)
//   trig_level                signed current threshold
//   buf_we/buf_waddr/buf_wdata  registered RAM write port, data = {current, voltage}
//   busy, done                status
//   trig_addr, rec_start      trigger sample address, first address of the record
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | waiting for arm, no writes
// S_FILL    | collecting the first pre_len samples, triggers ignored
// S_WAIT    | circular writes, watching for the trigger
// S_POST    | writing post-trigger samples (trigger sample counted)
// S_DONE    | record complete, done high until arm or abort

module ad_capture_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic                     sys_clk,
  input  logic                     rst_n,
  input  logic                     smp_valid,
  input  logic signed [DATA_W-1:0] smp_current,
  input  logic signed [DATA_W-1:0] smp_voltage,
  input  logic                     arm,
  input  logic                     abort,
  input  logic                     trig_force,
  input  logic [7:0]               decim,
  input  logic [ADDR_W-1:0]        pre_len,
  input  logic [ADDR_W-1:0]        post_len,
  input  logic signed [DATA_W-1:0] trig_level,
  output logic                     buf_we,
  output logic [ADDR_W-1:0]        buf_waddr,
  output logic [2*DATA_W-1:0]      buf_wdata,
  output logic                     busy,
  output logic                     done,
  output logic [ADDR_W-1:0]        trig_addr,
  output logic [ADDR_W-1:0]        rec_start
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_FILL = 3'd1,
    S_WAIT = 3'd2,
    S_POST = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] ONE_A = ADDR_W'(1);

  state_t                    state_q;
  logic [7:0]                decim_q;
  logic [ADDR_W-1:0]         pre_q;
  logic [ADDR_W-1:0]         post_q;
  logic signed [DATA_W-1:0]  lvl_q;
  logic [7:0]                dcnt_q;
  logic [ADDR_W-1:0]         wptr_q;
  logic [ADDR_W-1:0]         cnt_q;
  logic                      prev_below_q;
  logic                      force_pend_q;
  logic                      buf_we_q;
  logic [ADDR_W-1:0]         buf_waddr_q;
  logic [2*DATA_W-1:0]       buf_wdata_q;
  logic                      busy_q;
  logic                      done_q;
  logic [ADDR_W-1:0]         trig_addr_q;
  logic [ADDR_W-1:0]         rec_start_q;

  logic accept;
  logic below;
  logic trig_hit;

  always_comb begin
    accept   = smp_valid && (dcnt_q == 8'd0);
    below    = (smp_current < lvl_q);
    // A force request arriving in the same cycle as an accepted sample
    // triggers on that sample, without waiting for the pending flag.
    trig_hit = accept && (state_q == S_WAIT) &&
               ((!below && prev_below_q) || force_pend_q || trig_force);
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      decim_q      <= '0;
      pre_q        <= '0;
      post_q       <= '0;
      lvl_q        <= '0;
      dcnt_q       <= '0;
      wptr_q       <= '0;
      cnt_q        <= '0;
      prev_below_q <= 1'b0;
      force_pend_q <= 1'b0;
      buf_we_q     <= 1'b0;
      buf_waddr_q  <= '0;
      buf_wdata_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      trig_addr_q  <= '0;
      rec_start_q  <= '0;
    end else begin
      buf_we_q <= 1'b0;

      if (abort) begin
        // abort beats arm and suppresses any write from this cycle
        state_q      <= S_IDLE;
        busy_q       <= 1'b0;
        done_q       <= 1'b0;
        force_pend_q <= 1'b0;
      end else begin
        case (state_q)
          S_FILL, S_WAIT, S_POST: begin
            if (smp_valid) begin
              dcnt_q <= (dcnt_q == decim_q) ? 8'd0 : dcnt_q + 8'd1;
            end

            if ((state_q == S_WAIT) && trig_force) begin
              force_pend_q <= 1'b1;
            end

            if (accept) begin
              buf_we_q     <= 1'b1;
              buf_waddr_q  <= wptr_q;
              buf_wdata_q  <= {smp_current, smp_voltage};
              wptr_q       <= wptr_q + ONE_A;
              prev_below_q <= below;

              case (state_q)
                S_FILL: begin
                  if (cnt_q == ONE_A) begin
                    state_q <= S_WAIT;
                  end else begin
                    cnt_q <= cnt_q - ONE_A;
                  end
                end
                S_WAIT: begin
                  if (trig_hit) begin
                    trig_addr_q  <= wptr_q;
                    rec_start_q  <= wptr_q - pre_q;
                    force_pend_q <= 1'b0;
                    // post_len of 0 or 1 means the trigger sample is the whole tail
                    if (post_q <= ONE_A) begin
                      state_q <= S_DONE;
                      busy_q  <= 1'b0;
                      done_q  <= 1'b1;
                    end else begin
                      cnt_q   <= post_q - ONE_A;
                      state_q <= S_POST;
                    end
                  end
                end
                S_POST: begin
                  if (cnt_q == ONE_A) begin
                    state_q <= S_DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                  end else begin
                    cnt_q <= cnt_q - ONE_A;
                  end
                end
                default: ;
              endcase
            end
          end

          default: begin
            // IDLE and DONE both accept a new arm
            if (arm) begin
              decim_q      <= decim;
              pre_q        <= pre_len;
              post_q       <= post_len;
              lvl_q        <= trig_level;
              dcnt_q       <= '0;
              wptr_q       <= '0;
              cnt_q        <= pre_len;
              prev_below_q <= 1'b0;
              force_pend_q <= 1'b0;
              busy_q       <= 1'b1;
              done_q       <= 1'b0;
              state_q      <= (pre_len == '0) ? S_WAIT : S_FILL;
            end
          end
        endcase
      end
    end
  end

  assign buf_we    = buf_we_q;
  assign buf_waddr = buf_waddr_q;
  assign buf_wdata = buf_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign trig_addr = trig_addr_q;
  assign rec_start = rec_start_q;

endmodule

// File: tb/tb_ad_capture_ctrl.sv
module tb_ad_capture_ctrl;
  localparam int AW  = 10;
  localparam int AWB = 4;
  localparam int DW  = 16;

  logic                 sys_clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 smp_valid = 1'b0;
  logic signed [DW-1:0] smp_current = '0;
  logic signed [DW-1:0] smp_voltage = '0;
  logic                 arm = 1'b0;
  logic                 abort = 1'b0;
  logic                 trig_force = 1'b0;
  logic [7:0]           decim = '0;
  logic [AW-1:0]        pre_len = '0;
  logic [AW-1:0]        post_len = '0;
  logic signed [DW-1:0] trig_level = '0;

  logic          buf_we_a, busy_a, done_a;
  logic [AW-1:0] buf_waddr_a, trig_addr_a, rec_start_a;
  logic [2*DW-1:0] buf_wdata_a;
  logic           buf_we_b, busy_b, done_b;
  logic [AWB-1:0] buf_waddr_b, trig_addr_b, rec_start_b;
  logic [2*DW-1:0] buf_wdata_b;

  ad_capture_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut_a (
    .sys_clk(sys_clk), .rst_n(rst_n), .smp_valid(smp_valid),
    .smp_current(smp_current), .smp_voltage(smp_voltage),
    .arm(arm), .abort(abort), .trig_force(trig_force), .decim(decim),
    .pre_len(pre_len), .post_len(post_len), .trig_level(trig_level),
    .buf_we(buf_we_a), .buf_waddr(buf_waddr_a), .buf_wdata(buf_wdata_a),
    .busy(busy_a), .done(done_a), .trig_addr(trig_addr_a), .rec_start(rec_start_a));

  ad_capture_ctrl #(.ADDR_W(AWB), .DATA_W(DW)) dut_b (
    .sys_clk(sys_clk), .rst_n(rst_n), .smp_valid(smp_valid),
    .smp_current(smp_current), .smp_voltage(smp_voltage),
    .arm(arm), .abort(abort), .trig_force(trig_force), .decim(decim),
    .pre_len(pre_len[AWB-1:0]), .post_len(post_len[AWB-1:0]), .trig_level(trig_level),
    .buf_we(buf_we_b), .buf_waddr(buf_waddr_b), .buf_wdata(buf_wdata_b),
    .busy(busy_b), .done(done_b), .trig_addr(trig_addr_b), .rec_start(rec_start_b));

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [AW-1:0]   addr;
    logic [2*DW-1:0] data;
  } wr_t;

  // fields: decim pre post lvl base stp ncyc force_at nwr done use_b trig rec trig_b rec_b
  typedef struct {
    int decim; int pre; int post; int lvl; int base; int stp; int ncyc; int force_at;
    int nwr; bit done; bit use_b; int trig; int rec; int trig_b; int rec_b;
  } vec_t;

  wr_t qa[$];
  wr_t qb[$];
  int  checks = 0;
  int  errors = 0;
  bit  chk_b = 1'b0;
  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge sys_clk);
  endtask

  always @(negedge sys_clk) begin
    wr_t e;
    if (rst_n) begin
      if (buf_we_a) begin
        if (qa.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write_a: got write to %0d expected none", buf_waddr_a);
        end else begin
          e = qa.pop_front();
          chk("waddr_a", 64'(buf_waddr_a), 64'(e.addr));
          chk("wdata_a", 64'(buf_wdata_a), 64'(e.data));
        end
      end
      if (chk_b && buf_we_b) begin
        if (qb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write_b: got write to %0d expected none", buf_waddr_b);
        end else begin
          e = qb.pop_front();
          chk("waddr_b", 64'(buf_waddr_b), 64'(e.addr));
          chk("wdata_b", 64'(buf_wdata_b), 64'(e.data));
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_we"},    64'(buf_we_a), 64'd0);
    chk({tag, "_waddr"}, 64'(buf_waddr_a), 64'd0);
    chk({tag, "_wdata"}, 64'(buf_wdata_a), 64'd0);
    chk({tag, "_busy"},  64'(busy_a), 64'd0);
    chk({tag, "_done"},  64'(done_a), 64'd0);
    chk({tag, "_trig"},  64'(trig_addr_a), 64'd0);
    chk({tag, "_rec"},   64'(rec_start_a), 64'd0);
  endtask

  task automatic do_arm(input int d, input int pre, input int post, input int lvl);
    decim = 8'(d); pre_len = AW'(pre); post_len = AW'(post); trig_level = DW'(lvl);
    arm = 1'b1; smp_valid = 1'b0;
    step();
    arm = 1'b0;
    // configuration is don't-care after the arm cycle
    decim = 8'($urandom); pre_len = AW'($urandom); post_len = AW'($urandom);
    trig_level = DW'($urandom);
  endtask

  task automatic drive(input int c, input int cur, input bit push_a, input int addr_a);
    wr_t w;
    smp_valid = 1'b1;
    smp_current = DW'(cur);
    smp_voltage = DW'(16'h4000 + c * 3);
    if (push_a) begin
      w.addr = AW'(addr_a); w.data = {smp_current, smp_voltage};
      qa.push_back(w);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int acc;
    wr_t w;
    acc = 0;
    do_arm(v.decim, v.pre, v.post, v.lvl);
    chk_b = v.use_b;
    for (int c = 0; c < v.ncyc; c++) begin
      trig_force = (c == v.force_at);
      drive(c, v.base + v.stp * c, 1'b0, 0);
      if (c % (v.decim + 1) == 0) begin
        if (acc < v.nwr) begin
          w.addr = AW'(acc); w.data = {smp_current, smp_voltage};
          qa.push_back(w);
          if (v.use_b) begin
            w.addr = AW'(acc % 16);
            qb.push_back(w);
          end
        end
        acc++;
      end
      step();
    end
    smp_valid = 1'b0; trig_force = 1'b0;
    step(); step();
    chk($sformatf("v%0d_done", idx), 64'(done_a), 64'(v.done));
    chk($sformatf("v%0d_busy", idx), 64'(busy_a), 64'(!v.done));
    chk($sformatf("v%0d_pending_writes", idx), 64'(qa.size()), 64'd0);
    if (v.done) begin
      chk($sformatf("v%0d_trig_addr", idx), 64'(trig_addr_a), 64'(v.trig));
      chk($sformatf("v%0d_rec_start", idx), 64'(rec_start_a), 64'(v.rec));
    end
    if (v.use_b) begin
      chk($sformatf("v%0d_done_b", idx), 64'(done_b), 64'd1);
      chk($sformatf("v%0d_trig_addr_b", idx), 64'(trig_addr_b), 64'(v.trig_b));
      chk($sformatf("v%0d_rec_start_b", idx), 64'(rec_start_b), 64'(v.rec_b));
      chk($sformatf("v%0d_pending_writes_b", idx), 64'(qb.size()), 64'd0);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_b = 1'b0;
    chk($sformatf("v%0d_abort_status", idx), 64'({busy_a, done_a}), 64'd0);
    qa.delete(); qb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, 4, 4, 100,   0, 10, 20, -1, 14, 1, 0, 10,  6, 0, 0}; // ramp
    vecs[1] = '{2, 3, 2, 100,   0, 10, 20, -1,  6, 1, 0,  4,  1, 0, 0}; // decimation
    vecs[2] = '{0, 2, 2, 100, 500,  0, 30, -1, 30, 0, 0,  0,  0, 0, 0}; // flat above level
    vecs[3] = '{0, 5, 2, 1000,  0, 10, 15,  2, 15, 0, 0,  0,  0, 0, 0}; // force in FILL
    vecs[4] = '{0, 2, 3, 1000,  0, 10, 15,  6,  9, 1, 0,  6,  4, 0, 0}; // force same cycle
    vecs[5] = '{1, 2, 2, 1000,  0, 10, 15,  5,  5, 1, 0,  3,  1, 0, 0}; // force pending
    vecs[6] = '{0, 1, 0, 50,    0, 10, 12, -1,  6, 1, 0,  5,  4, 0, 0}; // post_len 0
    vecs[7] = '{0, 0, 2, 30,    0, 10, 10, -1,  5, 1, 0,  3,  3, 0, 0}; // pre_len 0
    vecs[8] = '{0, 2, 3, 200,   0, 10, 26, -1, 23, 1, 1, 20, 18, 4, 2}; // wrap (ADDR_W=4)

    #1;
    check_all_zero("reset");
    step(); step();
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // reset in the middle of a capture
    do_arm(0, 4, 4, 100);
    for (int c = 0; c < 6; c++) begin
      drive(c, 10 * c, 1'b1, c);
      step();
    end
    #2 rst_n = 1'b0;
    #1 check_all_zero("midreset");
    smp_valid = 1'b0;
    qa.delete();
    step();
    rst_n = 1'b1;
    step();
    run_vec(vecs[0], 100);

    // abort in POST after the trigger write plus one post write
    do_arm(0, 2, 5, 30);
    for (int c = 0; c < 5; c++) begin
      drive(c, 10 * c, 1'b1, c);
      step();
    end
    drive(5, 50, 1'b0, 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_post_we", 64'(buf_we_a), 64'd0);
    chk("abort_post_busy", 64'(busy_a), 64'd0);
    chk("abort_post_done", 64'(done_a), 64'd0);
    chk("abort_post_trig", 64'(trig_addr_a), 64'd3);
    for (int c = 6; c < 10; c++) begin
      drive(c, 10 * c, 1'b0, 0);
      step();
    end
    smp_valid = 1'b0;
    step();
    chk("abort_post_idle", 64'(busy_a), 64'd0);

    // arm and abort together from IDLE
    pre_len = AW'(2); post_len = AW'(2); trig_level = DW'(100);
    arm = 1'b1; abort = 1'b1;
    step();
    arm = 1'b0; abort = 1'b0;
    chk("arm_abort_busy", 64'(busy_a), 64'd0);
    for (int c = 0; c < 4; c++) begin
      drive(c, 10 * c, 1'b0, 0);
      step();
    end
    smp_valid = 1'b0;
    step();
    chk("arm_abort_still_idle", 64'({busy_a, done_a}), 64'd0);

    // arm while busy is ignored: write pointer keeps counting
    do_arm(0, 3, 2, 1000);
    drive(0, 0, 1'b1, 0); step();
    drive(1, 10, 1'b1, 1); step();
    arm = 1'b1; pre_len = '0; post_len = AW'(1); trig_level = '0;
    drive(2, 20, 1'b1, 2); step();
    arm = 1'b0;
    drive(3, 30, 1'b1, 3); step();
    smp_valid = 1'b0;
    step();
    chk("arm_busy_still_busy", 64'(busy_a), 64'd1);
    chk("arm_busy_not_done", 64'(done_a), 64'd0);
    chk("arm_busy_pending", 64'(qa.size()), 64'd0);
    abort = 1'b1; step(); abort = 1'b0; step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
